// File: rtl/bridge_pkg.sv
// Shared constants for the CPU data-bus bridge: UART register map and status bit layout.
package bridge_pkg;

   localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
   localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;

   localparam int unsigned STAT_TX_NOT_FULL  = 0;
   localparam int unsigned STAT_RX_NOT_EMPTY = 1;
   localparam int unsigned STAT_RX_OVERRUN   = 2;
   localparam int unsigned STAT_TX_DROP      = 3;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO. Pointers carry one extra MSB so full and empty are distinguishable.
module byte_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [7:0]    mem_q [DEPTH];
   logic          do_push, do_pop;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
   // Head reads as zero when empty so the reset value of the output is defined.
   assign head  = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];

   // A pop on a full FIFO frees the slot that a same-cycle push needs.
   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      wr_d    = do_push ? wr_q + PW'(1) : wr_q;
      rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage array; contents are meaningless while the pointers say empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/data_bus_bridge.sv
// MEM-stage data port bridge: routes CPU loads/stores to async SRAM or to a buffered UART.
module data_bus_bridge #(
   parameter int unsigned SRAM_AW        = 20,
   parameter logic [31:0] UART_DATA_ADDR = bridge_pkg::UART_DATA_ADDR,
   parameter logic [31:0] UART_STAT_ADDR = bridge_pkg::UART_STAT_ADDR,
   parameter int unsigned TX_DEPTH       = 4,
   parameter int unsigned RX_DEPTH       = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cpu_mem_write,
   input  logic               cpu_mem_read,
   input  logic [31:0]        cpu_mem_address,
   input  logic [31:0]        cpu_mem_write_data,
   output logic [31:0]        cpu_mem_read_data,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_wdata,
   input  logic [31:0]        sram_rdata,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic [7:0]         uart_tx_data,
   output logic               uart_tx_valid,
   input  logic               uart_tx_ready,
   input  logic [7:0]         uart_rx_data,
   input  logic               uart_rx_valid
);

   import bridge_pkg::*;

   logic        uart_data_sel, uart_stat_sel, sram_sel;
   logic        tx_push, tx_pop, tx_full, tx_empty;
   logic        rx_pop, rx_full, rx_empty;
   logic [7:0]  rx_head;
   logic        tx_drop_q, tx_drop_d, rx_overrun_q, rx_overrun_d;
   logic        stat_clr;
   logic [31:0] status;

   assign uart_data_sel = (cpu_mem_address == UART_DATA_ADDR);
   assign uart_stat_sel = (cpu_mem_address == UART_STAT_ADDR);
   assign sram_sel      = ~uart_data_sel & ~uart_stat_sel;

   assign sram_addr  = cpu_mem_address[SRAM_AW+1:2];
   assign sram_wdata = cpu_mem_write_data;
   assign sram_ce_n  = ~(sram_sel & (cpu_mem_read | cpu_mem_write));
   assign sram_oe_n  = ~(sram_sel & cpu_mem_read);
   assign sram_we_n  = ~(sram_sel & cpu_mem_write);

   assign tx_push       = cpu_mem_write & uart_data_sel;
   assign uart_tx_valid = ~tx_empty;
   assign tx_pop        = uart_tx_valid & uart_tx_ready;
   // A simultaneous write wins over a read, so a colliding load must not consume RX data.
   assign rx_pop        = cpu_mem_read & ~cpu_mem_write & uart_data_sel;
   assign stat_clr      = cpu_mem_read & uart_stat_sel;

   byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tx_push),
      .push_data (cpu_mem_write_data[7:0]),
      .pop       (tx_pop),
      .head      (uart_tx_data),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (uart_rx_valid),
      .push_data (uart_rx_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   // Sticky error flags: a status read clears them, but a same-cycle loss event keeps them set.
   always_comb begin
      tx_drop_d    = (tx_push & tx_full & ~tx_pop) | (tx_drop_q & ~stat_clr);
      rx_overrun_d = (uart_rx_valid & rx_full & ~rx_pop) | (rx_overrun_q & ~stat_clr);
   end

   // Sticky flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_drop_q    <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         tx_drop_q    <= tx_drop_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   // Status word and load-data mux.
   always_comb begin
      status                    = '0;
      status[STAT_TX_NOT_FULL]  = ~tx_full;
      status[STAT_RX_NOT_EMPTY] = ~rx_empty;
      status[STAT_RX_OVERRUN]   = rx_overrun_q;
      status[STAT_TX_DROP]      = tx_drop_q;

      cpu_mem_read_data = 32'h0;
      if (cpu_mem_read) begin
         if (uart_data_sel)      cpu_mem_read_data = {24'h0, rx_head};
         else if (uart_stat_sel) cpu_mem_read_data = status;
         else                    cpu_mem_read_data = sram_rdata;
      end
   end

endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
- Sits directly downstream of the pipelined CPU's MEM-stage data port. Consumes the CPU's per-cycle memory request: write strobe, read strobe, address, write data.
- Routes each request either to the external asynchronous SRAM or to a memory-mapped UART register pair.
- Returns read data combinationally in the same cycle, which the MEM/WB register samples.
- Buffers UART traffic in one TX FIFO and one RX FIFO so that CPU stores and loads never stall.

Parameters:
- SRAM_AW, 20, SRAM word-address width; the SRAM word address is cpu_mem_address[SRAM_AW+1:2].
- UART_DATA_ADDR, 32'hBFD0_03F8, byte address of the UART data register.
- UART_STAT_ADDR, 32'hBFD0_03FC, byte address of the UART status register.
- TX_DEPTH, 4, TX FIFO entries; must be a power of two, at least 2.
- RX_DEPTH, 4, RX FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_mem_write  in  1  store in the MEM stage this cycle.
- cpu_mem_read  in  1  load in the MEM stage this cycle.
- cpu_mem_address  in  32  byte address (word-aligned).
- cpu_mem_write_data  in  32  store data.
- cpu_mem_read_data  out  32  load data, combinational.
- sram_addr  out  SRAM_AW  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.
- sram_ce_n  out  1  SRAM chip enable, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.
- sram_we_n  out  1  SRAM write enable, active-low.
- uart_tx_data  out  8  byte offered to the UART transmitter.
- uart_tx_valid  out  1  TX FIFO non-empty.
- uart_tx_ready  in  1  transmitter accepts the byte when valid and ready are both high.
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  one-cycle strobe: uart_rx_data is valid.

Behaviour:
- Decode:
  - uart_data_sel = (addr == UART_DATA_ADDR).
  - uart_stat_sel = (addr == UART_STAT_ADDR).
  - sram_sel = neither of the above.
  - Comparisons use all 32 bits.
- cpu_mem_write and cpu_mem_read are never both high. If they are, the write takes effect and the read data is still returned, with no RX pop.
- SRAM signals, all combinational:
  - sram_ce_n = ~(sram_sel & (rd|wr)).
  - sram_oe_n = ~(sram_sel & rd).
  - sram_we_n = ~(sram_sel & wr).
  - sram_addr and sram_wdata are driven from the address and write data every cycle regardless of select.
- Read mux, combinational:
  - sram_sel: sram_rdata.
  - uart_data_sel: {24'b0, rx_head} when the RX FIFO is non-empty, else 32'h0.
  - uart_stat_sel: {28'b0, tx_drop, rx_overrun, rx_not_empty, tx_not_full}.
  - cpu_mem_read low: 32'h0.
- TX path:
  - A write with uart_data_sel pushes cpu_mem_write_data[7:0] if the TX FIFO is not full.
  - If the TX FIFO is full, the byte is discarded and tx_drop is set (sticky).
  - The FIFO head drives uart_tx_data; uart_tx_valid = TX FIFO non-empty.
  - Pop on (uart_tx_valid & uart_tx_ready).
  - Push and pop in the same cycle on a full FIFO: the pop frees a slot and the push is accepted; tx_drop is not set.
- RX path:
  - uart_rx_valid pushes uart_rx_data. If the RX FIFO is full, the byte is discarded and rx_overrun is set (sticky).
  - A read with uart_data_sel pops the head when the FIFO is non-empty. It pops exactly once per access, because the MEM stage never holds an access for more than one cycle.
  - Push and pop in the same cycle on a full FIFO: both occur and there is no overrun.
  - Push and pop in the same cycle on an empty FIFO: the read returns 0, the push is accepted, and no pop occurs.
- Sticky flags:
  - A read with uart_stat_sel clears rx_overrun and tx_drop at the next edge. The value returned by that read still shows the set flags.
  - A set event in the same cycle as the clearing read wins: the flag stays 1.
- Latency:
  - A push is visible in status, uart_tx_valid and the read mux on the next cycle.
  - SRAM access and status reads have zero-cycle latency.
- Reset (reset low, asynchronous):
  - Both FIFOs empty, pointers 0, sticky flags 0.
  - uart_tx_valid = 0, uart_tx_data = 8'h00.
  - Status reads 32'h1.
  - Combinational outputs follow their inputs, with the UART-derived terms at their reset values.
  - Reset mid-transfer drops all buffered bytes; there is no partial-state recovery.
- FIFO pointer width is log2(DEPTH)+1. Full and empty are distinguished by the MSB of the pointers; pointers wrap naturally.

Decomposition:
- Shared package bridge_pkg holds:
  - address constants UART_DATA_ADDR and UART_STAT_ADDR;
  - status bit indices STAT_TX_NOT_FULL=0, STAT_RX_NOT_EMPTY=1, STAT_RX_OVERRUN=2, STAT_TX_DROP=3.
- One sub-module, byte_fifo, instantiated twice (TX and RX):
  - parameter DEPTH;
  - ports clk, reset, push, push_data[7:0], pop, head[7:0], full, empty;
  - show-ahead, and the same reset behaviour as above.

Test Plan:
- Post-reset: read 0xBFD003FC gives 32'h1; read 0x00000010 with sram_rdata=32'hDEADBEEF gives 32'hDEADBEEF, sram_oe_n=0, sram_addr=4.
- SRAM store of 32'h12345678 to 0x00000020 gives sram_we_n=0, sram_ce_n=0, sram_addr=8 and sram_wdata=32'h12345678 in that cycle; UART state unchanged.
- TX, uart_tx_ready=0:
  - Store 0x41, 0x42, 0x43, 0x44 to 0xBFD003F8, then uart_tx_valid=1 and uart_tx_data=8'h41, and status bit0 reads 0.
  - A fifth store sets status bit3.
  - Raise uart_tx_ready for 4 cycles: bytes 41, 42, 43, 44 leave in order, then uart_tx_valid=0.
- RX overrun: pulse uart_rx_valid 5 times with bytes 1–5, then status reads 32'h7; data reads return 1, 2, 3, 4 then 0; the next status read returns 32'h1.
- RX simultaneous on a full FIFO: a data read and a push of 0x55 in the same cycle return the head, and rx_overrun stays 0; after four more reads the last returns 0x55.
- Assert reset while the TX FIFO holds 2 bytes and rx_overrun=1: uart_tx_valid drops immediately (without waiting for a clock edge), and status reads 32'h1 after release.
